imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Loads a program into the fetch stage's instruction memory from a byte stream before the pipeline runs. It holds the pipeline in reset while loading. It assembles big-endian 32-bit words, writes them to sequential word addresses, and checks an XOR checksum. It releases the pipeline reset only on a good load. It sits directly upstream of the pipeline top: it drives the instruction-memory write port and the pipeline's reset input.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W
LEN_W, 16, width of the word-count header field (must be >= ADDR_W+1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
rx_valid  input  1  byte-stream valid
rx_data  input  8  byte-stream data
rx_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  instruction word for the write
cpu_reset  output  1  drives the pipeline reset; high except in DONE
load_done  output  1  high in DONE
load_error  output  1  high in ERR
words_loaded  output  ADDR_W+1  number of words written in the current/last load

Behaviour:
- Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, words_loaded=0. All counters and the checksum clear to 0.
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N*4 data bytes (each word MSB first), then 1 checksum byte. The checksum is the XOR of every byte from LEN_HI through the last data byte.
- Byte accepted iff rx_valid && rx_ready at a rising edge. rx_ready is registered: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 elsewhere. The source may hold rx_valid indefinitely; no byte is lost or duplicated.
- States:
  - IDLE: start -> LEN_HI.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte. If N > MAX_WORDS -> ERR. If N == 0 -> CHECK. Otherwise -> DATA.
  - DATA: shift bytes into a 32-bit assembly register, with a 2-bit byte counter.
    - On the 4th byte: next cycle imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word.
    - Word index and words_loaded then increment.
    - The 4th byte of word N-1 -> CHECK.
  - CHECK: accept byte. Equal to running XOR -> DONE; otherwise -> ERR.
  - DONE: load_done=1, cpu_reset=0 (both registered, the cycle after the checksum byte is accepted). start -> LEN_HI.
  - ERR: load_error=1, cpu_reset=1. start -> LEN_HI.
- Entering LEN_HI from any state:
  - cpu_reset=1 on that same edge.
  - load_done, load_error, words_loaded, word index, byte counter and checksum all clear.
- start in LEN_HI/LEN_LO/DATA/CHECK: ignored.
- Simultaneous start and reset: reset wins.
- reset mid-load:
  - Next edge goes to IDLE. Any pending imem_we is cancelled and cpu_reset stays 1.
  - Words already written remain in memory; the loader does not scrub them.
- Word index never wraps: N=MAX_WORDS writes addresses 0..MAX_WORDS-1 exactly once.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- No throughput bubble: one byte per cycle is sustained, including across word boundaries and the imem_we cycle.

Test Plan:
- Good 2-word load, bytes 00 02 20 08 00 05 00 00 00 00 2F, rx_valid held high:
  - imem_we pulses twice: addr 0 / 0x20080005, then addr 1 / 0x00000000.
  - load_done=1 and cpu_reset=0 one cycle after byte 2F; words_loaded=2.
- Same stream with checksum 2E: both words are written, then load_error=1, cpu_reset stays 1, load_done=0.
- Header N=0x0101 (257) with ADDR_W=8:
  - ERR the cycle after LEN_LO is accepted; no imem_we pulse; rx_ready=0.
- N=0, stream 00 00 00: DONE with no writes and words_loaded=0. Stream 00 00 01: ERR.
- Random rx_valid gaps (50% duty) on the 2-word stream: identical writes and DONE as the first scenario. A start pulse mid-DATA changes nothing.
- reset asserted after the 6th byte of the first scenario:
  - IDLE next cycle, all outputs at reset values, no further imem_we.
  - A subsequent start plus the full stream completes to DONE.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: fills instruction memory with big-endian words, verifies an
// XOR checksum and releases the pipeline reset only after a good load.
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;

  logic              accept;
  logic [LEN_W-1:0]  len_full;

  assign accept   = rx_valid && rx_ready_q;
  assign len_full = LEN_W'({len_hi_q, rx_data});

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_idx_d   = word_idx_q;
    len_d        = len_q;
    len_hi_d     = len_hi_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    csum_d       = csum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          len_d  = len_full[ADDR_W:0];
          if (len_full > LEN_W'(MAX_WORDS)) state_d = S_ERR;
          else if (len_full == '0)          state_d = S_CHECK;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = {asm_q[15:0], rx_data};
          // Fourth byte completes the word; the write goes out on the next cycle while
          // the stream keeps flowing into the following word.
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_W-1:0];
            imem_wdata_d = {asm_q, rx_data};
            word_idx_d   = word_idx_q + (ADDR_W+1)'(1);
            if (word_idx_q == len_q - (ADDR_W+1)'(1)) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // A new load always begins from a clean slate.
    if (state_d == S_LEN_HI && state_q != S_LEN_HI) begin
      word_idx_d = '0;
      len_d      = '0;
      len_hi_d   = '0;
      byte_cnt_d = '0;
      asm_d      = '0;
      csum_d     = '0;
    end

    rx_ready_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CHECK);
    cpu_reset_d  = (state_d != S_DONE);
    load_done_d  = (state_d == S_DONE);
    load_error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      word_idx_q   <= '0;
      len_q        <= '0;
      len_hi_q     <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      len_hi_q     <= len_hi_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by the stimulus and
// popped by an independent monitor whenever imem_we pulses.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, imem_we, cpu_reset, load_done, load_error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  imem_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.data));
        check("cpu_reset_while_loading", 64'(cpu_reset), 64'd1);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_two_words();
    wr_t w;
    w.addr = 8'd0; w.data = 32'h2008_0005; exp_q.push_back(w);
    w.addr = 8'd1; w.data = 32'h0000_0000; exp_q.push_back(w);
  endtask

  task automatic send_stream(input logic [7:0] b[$], input bit gaps, input int start_at,
                             output int ncyc);
    int  c0;
    int  t;
    bit  acc;
    c0 = cycle;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b[i];
      if (i == start_at) start = 1'b1;
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 50) begin
        acc = rx_ready;
        @(negedge clk);
        start = 1'b0;
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %0d got rx_ready=0 expected 1", i);
      end
    end
    rx_valid = 1'b0;
    ncyc = cycle - c0;
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] s[$];
    int n;

    good = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    bad  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2E};

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_error", 64'(load_error), 64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good 2-word load, valid held high
    push_two_words();
    pulse_start();
    check("len_hi_rx_ready", 64'(rx_ready), 64'd1);
    send_stream(good, 1'b0, -1, n);
    check("no_bubble_cycles", 64'(n), 64'd11);
    check("good_load_done", 64'(load_done), 64'd1);
    check("good_cpu_reset", 64'(cpu_reset), 64'd0);
    check("good_load_error", 64'(load_error), 64'd0);
    check("good_words_loaded", 64'(words_loaded), 64'd2);
    check("good_rx_ready", 64'(rx_ready), 64'd0);
    check("good_pending_writes", 64'(exp_q.size()), 64'd0);

    // Bad checksum
    push_two_words();
    pulse_start();
    check("restart_load_done", 64'(load_done), 64'd0);
    check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    check("restart_words_loaded", 64'(words_loaded), 64'd0);
    send_stream(bad, 1'b0, -1, n);
    check("badsum_load_error", 64'(load_error), 64'd1);
    check("badsum_cpu_reset", 64'(cpu_reset), 64'd1);
    check("badsum_load_done", 64'(load_done), 64'd0);
    check("badsum_words_loaded", 64'(words_loaded), 64'd2);
    check("badsum_pending_writes", 64'(exp_q.size()), 64'd0);

    // Oversize header (257 words)
    pulse_start();
    s = '{8'h01, 8'h01};
    send_stream(s, 1'b0, -1, n);
    check("oversize_load_error", 64'(load_error), 64'd1);
    check("oversize_rx_ready", 64'(rx_ready), 64'd0);
    check("oversize_cpu_reset", 64'(cpu_reset), 64'd1);
    repeat (3) @(negedge clk);

    // Empty program, good and bad checksum
    pulse_start();
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 1'b0, -1, n);
    check("empty_load_done", 64'(load_done), 64'd1);
    check("empty_words_loaded", 64'(words_loaded), 64'd0);
    pulse_start();
    s = '{8'h00, 8'h00, 8'h01};
    send_stream(s, 1'b0, -1, n);
    check("empty_bad_load_error", 64'(load_error), 64'd1);
    check("empty_bad_load_done", 64'(load_done), 64'd0);

    // Gapped stream with a stray start in DATA
    push_two_words();
    pulse_start();
    send_stream(good, 1'b1, 5, n);
    check("gaps_load_done", 64'(load_done), 64'd1);
    check("gaps_words_loaded", 64'(words_loaded), 64'd2);
    check("gaps_pending_writes", 64'(exp_q.size()), 64'd0);

    // Reset sampled together with the 6th byte cancels the load and its pending write
    pulse_start();
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    send_stream(s, 1'b0, -1, n);
    rx_valid = 1'b1; rx_data = 8'h05; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    check("midrst_rx_ready", 64'(rx_ready), 64'd0);
    check("midrst_imem_we", 64'(imem_we), 64'd0);
    check("midrst_imem_addr", 64'(imem_addr), 64'd0);
    check("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("midrst_words_loaded", 64'(words_loaded), 64'd0);
    repeat (4) @(negedge clk);
    check("midrst_idle_rx_ready", 64'(rx_ready), 64'd0);
    push_two_words();
    pulse_start();
    send_stream(good, 1'b0, -1, n);
    check("reload_load_done", 64'(load_done), 64'd1);
    check("reload_cpu_reset", 64'(cpu_reset), 64'd0);
    check("reload_words_loaded", 64'(words_loaded), 64'd2);
    repeat (2) @(negedge clk);
    check("final_pending_writes", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
